// File: rtl/c17_test_sequencer_if.sv
// Handshake and DUT-facing bus of the C17 exhaustive test sequencer.
// The master modport is the sequencer side. The slave modport is the environment side.
interface c17_test_sequencer_if;
  logic       start;
  logic       abort;
  logic [4:0] dut_in;
  logic [1:0] dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic       aborted;
  logic [5:0] err_count;
  logic [4:0] first_fail_vec;
  logic       first_fail_valid;

  modport master (
    input  start, abort, dut_out,
    output dut_in, busy, done, pass, aborted, err_count, first_fail_vec, first_fail_valid
  );

  modport slave (
    output start, abort, dut_out,
    input  dut_in, busy, done, pass, aborted, err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/c17_test_sequencer.sv
// Exhaustive tester for the ISCAS C17 circuit. It steps through all 32 input vectors,
// waits SETTLE_CYCLES cycles on each one and compares the response to an internal golden model.
module c17_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  c17_test_sequencer_if.master  seqIf
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [4:0] vec_q, vec_d;
  logic [3:0] settle_q, settle_d;
  logic [5:0] errCount_q, errCount_d;
  logic [4:0] firstFailVec_q, firstFailVec_d;
  logic       firstFailValid_q, firstFailValid_d;
  logic       pass_q, pass_d;
  logic       aborted_q, aborted_d;
  logic       inRun;
  logic       mismatch;

  // Reference C17 netlist as six NAND gates. Bit 0 is G6gat and bit 1 is G7gat.
  function automatic logic [1:0] golden(input logic [4:0] v);
    logic w1, w2, w3, w4;
    w1 = ~(v[4] & v[1]);
    w2 = ~(v[4] & v[0]);
    w3 = ~(w1 & v[3]);
    w4 = ~(w1 & v[2]);
    return {~(w4 & w3), ~(w2 & w3)};
  endfunction

  assign inRun    = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
  assign mismatch = (seqIf.dut_out != golden(vec_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      vec_q            <= '0;
      settle_q         <= '0;
      errCount_q       <= '0;
      firstFailVec_q   <= '0;
      firstFailValid_q <= 1'b0;
      pass_q           <= 1'b0;
      aborted_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      vec_q            <= vec_d;
      settle_q         <= settle_d;
      errCount_q       <= errCount_d;
      firstFailVec_q   <= firstFailVec_d;
      firstFailValid_q <= firstFailValid_d;
      pass_q           <= pass_d;
      aborted_q        <= aborted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (seqIf.start) state_d = APPLY;
      APPLY:   state_d = seqIf.abort ? IDLE : SETTLE;
      SETTLE:  begin
        if (seqIf.abort)                state_d = IDLE;
        else if (settle_q == SETTLE_LAST) state_d = CHECK;
      end
      CHECK:   begin
        if (seqIf.abort)        state_d = IDLE;
        else if (vec_q == 5'd31) state_d = DONE;
        else                    state_d = APPLY;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An abort takes priority over the comparison made in the same cycle, so that result is dropped.
  always_comb begin
    vec_d            = vec_q;
    settle_d         = settle_q;
    errCount_d       = errCount_q;
    firstFailVec_d   = firstFailVec_q;
    firstFailValid_d = firstFailValid_q;
    pass_d           = pass_q;
    aborted_d        = aborted_q;
    case (state_q)
      IDLE: begin
        if (seqIf.start) begin
          vec_d            = '0;
          errCount_d       = '0;
          firstFailVec_d   = '0;
          firstFailValid_d = 1'b0;
          pass_d           = 1'b0;
          aborted_d        = 1'b0;
        end
      end
      APPLY:  settle_d = '0;
      SETTLE: settle_d = settle_q + 4'd1;
      CHECK: begin
        if (!seqIf.abort) begin
          if (mismatch) begin
            if (errCount_q != 6'd32) errCount_d = errCount_q + 6'd1;
            if (!firstFailValid_q) begin
              firstFailVec_d   = vec_q;
              firstFailValid_d = 1'b1;
            end
          end
          if (vec_q != 5'd31) vec_d = vec_q + 5'd1;
        end
      end
      DONE:    pass_d = (errCount_q == 6'd0);
      default: ;
    endcase
    if (inRun && seqIf.abort) begin
      aborted_d = 1'b1;
      pass_d    = 1'b0;
    end
  end

  always_comb begin
    seqIf.busy   = 1'b0;
    seqIf.done   = 1'b0;
    seqIf.dut_in = '0;
    case (state_q)
      APPLY, SETTLE, CHECK: begin
        seqIf.busy   = 1'b1;
        seqIf.dut_in = vec_q;
      end
      DONE:    seqIf.done = 1'b1;
      default: ;
    endcase
  end

  assign seqIf.pass             = pass_q;
  assign seqIf.aborted          = aborted_q;
  assign seqIf.err_count        = errCount_q;
  assign seqIf.first_fail_vec   = firstFailVec_q;
  assign seqIf.first_fail_valid = firstFailValid_q;

endmodule

// File: tb/tb_c17_test_sequencer.sv
// Randomized self-checking bench for c17_test_sequencer. A table-driven fake DUT answers each vector,
// and a sum-of-products C17 model predicts timing, error counts and first failures.
module tb_c17_test_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] respTable [32];
  int         compared   = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  c17_test_sequencer_if ifA ();
  c17_test_sequencer_if ifB ();

  assign ifA.dut_out = respTable[ifA.dut_in];
  assign ifB.dut_out = respTable[ifB.dut_in];

  c17_test_sequencer #(.SETTLE_CYCLES(1))  dutA (.clk(clk), .rst_n(rst_n), .seqIf(ifA));
  c17_test_sequencer #(.SETTLE_CYCLES(15)) dutB (.clk(clk), .rst_n(rst_n), .seqIf(ifB));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, required %0d", tag, observed, expected);
    end
  endtask

  // C17 reduced to two-level logic: G6 = G1.G5 + G4.!(G2.G5), G7 = !(G2.G5).(G3 + G4)
  function automatic logic [1:0] refGolden(input logic [4:0] v);
    logic g1, g2, g3, g4, g5;
    {g5, g4, g3, g2, g1} = v;
    return {~(g2 & g5) & (g3 | g4), (g1 & g5) | (g4 & ~(g2 & g5))};
  endfunction

  function automatic logic [20:0] snap(input bit sel);
    if (sel) return {ifB.dut_in, ifB.busy, ifB.done, ifB.pass, ifB.aborted,
                     ifB.err_count, ifB.first_fail_vec, ifB.first_fail_valid};
    return {ifA.dut_in, ifA.busy, ifA.done, ifA.pass, ifA.aborted,
            ifA.err_count, ifA.first_fail_vec, ifA.first_fail_valid};
  endfunction

  task automatic drive(input bit sel, input logic st, input logic ab);
    if (sel) begin ifB.start = st; ifB.abort = ab; end
    else     begin ifA.start = st; ifA.abort = ab; end
  endtask

  // Modes: 0 golden DUT, 1 vector 5 inverted, 2 stuck at 00, 3 random faults.
  task automatic applyStimulus(input int mode);
    for (int v = 0; v < 32; v++) begin
      case (mode)
        0: respTable[v] = refGolden(5'(v));
        1: respTable[v] = (v == 5) ? ~refGolden(5'(v)) : refGolden(5'(v));
        2: respTable[v] = 2'b00;
        default: respTable[v] = refGolden(5'(v)) ^
                 (($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      endcase
    end
  endtask

  // One run from a start pulse. Optionally abort, reset, or re-pulse start at a given run cycle.
  task automatic runSeq(input bit sel, input int settle, input int abortCycle,
                        input int resetCycle, input int restartCycle, input string name);
    int          period, doneAt, stopCycle, doneCycle, doneCount, seqBad, checked, expErr, expFirst;
    bit          active, expValid;
    logic [20:0] s;
    logic [5:0]  errAfterStop;
    period    = 2 + settle;
    doneAt    = 32 * period + 1;
    stopCycle = (abortCycle != 0) ? abortCycle : resetCycle;
    doneCycle = -1;
    doneCount = 0;
    seqBad    = 0;
    errAfterStop = '0;
    @(negedge clk);
    drive(sel, 1'b1, 1'b0);
    @(posedge clk);
    #1 drive(sel, 1'b0, 1'b0);
    for (int c = 1; c <= doneAt + 5; c++) begin
      @(negedge clk);
      s      = snap(sel);
      active = (c <= 32 * period) && (stopCycle == 0 || c <= stopCycle);
      if (s[20:16] !== (active ? 5'((c - 1) / period) : 5'd0) || s[15] !== active) seqBad++;
      if (s[14] === 1'b1) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = c;
      end
      if (stopCycle != 0 && c == stopCycle + 1) errAfterStop = s[11:6];
      if (c == abortCycle)   drive(sel, 1'b0, 1'b1);
      if (c == restartCycle) drive(sel, 1'b1, 1'b0);
      if (c == resetCycle) begin
        rst_n = 1'b0;
        #1 checkOutput({name, " outputs in reset"}, 32'(snap(sel)), 32'd0);
        #2 rst_n = 1'b1;
      end
      @(posedge clk);
      #1 drive(sel, 1'b0, 1'b0);
    end
    s = snap(sel);
    checkOutput({name, " dut_in/busy sequence errors"}, seqBad, 0);
    if (stopCycle == 0) begin
      checkOutput({name, " done cycle"}, doneCycle, doneAt);
      checkOutput({name, " done pulses"}, doneCount, 1);
    end else begin
      checkOutput({name, " done pulses"}, doneCount, 0);
    end
    checked = (stopCycle == 0) ? 32 : (resetCycle != 0) ? 0 : (abortCycle - 1) / period;
    expErr   = 0;
    expFirst = 0;
    expValid = 1'b0;
    for (int v = 0; v < checked; v++) begin
      if (respTable[v] !== refGolden(5'(v))) begin
        if (!expValid) expFirst = v;
        expValid = 1'b1;
        expErr++;
      end
    end
    checkOutput({name, " err_count"}, 32'(s[11:6]), expErr);
    checkOutput({name, " first_fail_valid"}, 32'(s[0]), 32'(expValid));
    checkOutput({name, " first_fail_vec"}, 32'(s[5:1]), expFirst);
    checkOutput({name, " pass"}, 32'(s[13]), 32'(stopCycle == 0 && expErr == 0));
    checkOutput({name, " aborted"}, 32'(s[12]), 32'(abortCycle != 0));
    if (stopCycle != 0) checkOutput({name, " err_count held"}, 32'(s[11:6]), 32'(errAfterStop));
  endtask

  initial begin
    ifA.start = 1'b0; ifA.abort = 1'b0;
    ifB.start = 1'b0; ifB.abort = 1'b0;
    applyStimulus(0);
    rst_n = 1'b0;
    #23;
    checkOutput("reset A", 32'(snap(1'b0)), 32'd0);
    checkOutput("reset B", 32'(snap(1'b1)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0); runSeq(1'b0, 1, 0, 0, 0, "golden");
    applyStimulus(1); runSeq(1'b0, 1, 0, 0, 0, "invert5");
    applyStimulus(2); runSeq(1'b0, 1, 0, 0, 0, "stuck00");
    applyStimulus(3); runSeq(1'b0, 1, 32, 0, 0, "abort_v10");
    applyStimulus(3); runSeq(1'b0, 1, 0, 0, 40, "restart_busy");
    applyStimulus(3);
    respTable[3] = ~refGolden(5'd3);
    runSeq(1'b0, 1, 0, 61, 0, "reset_v20");
    applyStimulus(0); runSeq(1'b0, 1, 0, 0, 0, "after_reset");
    for (int r = 0; r < 2; r++) begin
      applyStimulus(3); runSeq(1'b0, 1, 0, 0, 0, "random");
    end
    applyStimulus(3); runSeq(1'b1, 15, 0, 0, 0, "settle15");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/c17_test_sequencer.md
C17_TEST_SEQUENCER -- requirements
Module: c17_test_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, cycles waited between applying a vector and sampling the DUT (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin an exhaustive run.
REQ-005 SHALL have port abort  input  1  terminate the current run.
REQ-006 SHALL have port dut_in  output  5  vector to the C17 DUT: bit0=G1gat, bit1=G2gat, bit2=G3gat, bit3=G4gat, bit4=G5gat.
REQ-007 SHALL have port dut_out  input  2  DUT response: bit0=G6gat, bit1=G7gat.
REQ-008 SHALL have port busy  output  1  run in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at normal run completion.
REQ-010 SHALL have port pass  output  1  last completed run had zero mismatches.
REQ-011 SHALL have port aborted  output  1  last run was terminated by abort.
REQ-012 SHALL have port err_count  output  6  mismatching vectors in current/last run.
REQ-013 SHALL have port first_fail_vec  output  5  first mismatching vector.
REQ-014 SHALL have port first_fail_valid  output  1  first_fail_vec is meaningful.

Function
REQ-015 SHALL implement states IDLE, APPLY, SETTLE, CHECK, DONE.
REQ-016 SHALL, in IDLE with start=1, clear err_count, pass, aborted, first_fail_valid, first_fail_vec, set vector counter to 0, and enter APPLY.
REQ-017 SHALL ignore start in every state other than IDLE.
REQ-018 SHALL drive dut_in = vector counter in APPLY, SETTLE, CHECK; dut_in = 0 in IDLE and DONE.
REQ-019 SHALL stay in APPLY 1 cycle, SETTLE exactly SETTLE_CYCLES cycles, CHECK 1 cycle; per-vector time = 2+SETTLE_CYCLES cycles.
REQ-020 SHALL compute the golden response internally: w1=NAND(G5,G2), w2=NAND(G5,G1), w3=NAND(w1,G4), w4=NAND(w1,G3), G6=NAND(w2,w3), G7=NAND(w4,w3).
REQ-021 SHALL, in CHECK, compare dut_out to golden for the current vector; on mismatch increment err_count (6-bit, max 32, no wrap).
REQ-022 SHALL, on the first mismatch of a run only, load first_fail_vec with the vector and set first_fail_valid=1.
REQ-023 SHALL, leaving CHECK, go to APPLY with counter+1 if counter<31, else to DONE.
REQ-024 SHALL, in DONE, assert done for exactly one cycle, set pass=(err_count==0), and return to IDLE.
REQ-025 SHALL assert busy in APPLY, SETTLE, CHECK; deasserted in IDLE and DONE.
REQ-026 SHALL, with start sampled in cycle 0, place CHECK of vector k in cycle (k+1)*(2+SETTLE_CYCLES) and done in cycle 32*(2+SETTLE_CYCLES)+1.
REQ-027 SHALL, on abort=1 in APPLY/SETTLE/CHECK, enter IDLE next cycle, set aborted=1, pass=0, not pulse done, and discard the comparison of that cycle.
REQ-028 SHALL give abort priority over the CHECK comparison when both occur in the same cycle; abort in IDLE/DONE has no effect.
REQ-029 SHALL hold err_count, first_fail_*, pass, aborted stable from run end until the next accepted start.

Reset
REQ-030 SHALL, while rst_n=0, force state IDLE, counter 0, dut_in 0, busy 0, done 0, pass 0, aborted 0, err_count 0, first_fail_vec 0, first_fail_valid 0, regardless of clk.
REQ-031 SHALL, on reset assertion mid-run, abandon the run with no done pulse; the first start after rst_n=1 is accepted normally.

Verification
REQ-032 SHALL cover: golden-equivalent DUT, SETTLE_CYCLES=1, start pulse -> dut_in steps 0..31, done in cycle 97, pass=1, err_count=0, first_fail_valid=0.
REQ-033 SHALL cover: DUT correct except dut_out inverted for vector 5 only -> err_count=1, first_fail_vec=5, first_fail_valid=1, pass=0.
REQ-034 SHALL cover: DUT with dut_out stuck at 2'b00 -> vector 0 passes (golden 00), vector 31 fails (golden 2'b01), first_fail_vec = lowest vector with nonzero golden, err_count equal to the golden-nonzero vector count from the reference model.
REQ-035 SHALL cover: abort during SETTLE of vector 10 -> busy low next cycle, aborted=1, no done pulse, err_count unchanged thereafter; new start clears aborted.
REQ-036 SHALL cover: start reasserted while busy -> ignored, run timing unchanged; rst_n low during vector 20 -> all outputs zero immediately.
REQ-037 SHALL cover: SETTLE_CYCLES=15 -> dut_in stable 17 cycles per vector, done in cycle 545.
